// File: rtl/shift_add_mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand width
// and controller state encoding, used by both the block and its bench.
package shift_add_mul_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_mul_ctrl.sv
// Controller for the shift-and-add multiplier: FSM, bit counter and the
// registered done pulse. Driven only by the datapath's mult_zero status flag.
module shift_add_mul_ctrl
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic mult_zero_i,
  output logic load_o,
  output logic run_o,
  output logic fix_o,
  output logic busy_o,
  output logic done_o
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q;
  logic          count_max;

  // Asserted on the RUN edge that brings the counter to WIDTH.
  assign count_max = (count_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_o  = 1'b0;
    run_o   = 1'b0;
    fix_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load_o  = 1'b1;
          count_d = '0;
          state_d = mult_zero_i ? FIX : RUN;
        end
      end
      RUN: begin
        run_o   = 1'b1;
        count_d = count_q + CW'(1);
        if (mult_zero_i || count_max) state_d = FIX;
      end
      FIX: begin
        fix_o   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= fix_o;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;

endmodule

// File: rtl/shift_add_mul.sv
// Iterative shift-and-add multiplier (signed or unsigned) with early
// termination; datapath here, sequencing in shift_add_mul_ctrl.
module shift_add_mul
  import shift_add_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mult_q, mult_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               neg_q, neg_d;

  logic               load, run, fix, mult_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Magnitudes fit in WIDTH unsigned bits, so the most negative value maps cleanly.
  assign a_mag = (signed_mode && a_in[WIDTH-1]) ? (~a_in + WIDTH'(1)) : a_in;
  assign b_mag = (signed_mode && b_in[WIDTH-1]) ? (~b_in + WIDTH'(1)) : b_in;

  assign mult_zero = load ? (b_in == '0) : (mult_q[WIDTH-1:1] == '0);

  shift_add_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .mult_zero_i (mult_zero),
    .load_o      (load),
    .run_o       (run),
    .fix_o       (fix),
    .busy_o      (busy),
    .done_o      (done)
  );

  always_comb begin
    mcand_d   = mcand_q;
    mult_d    = mult_q;
    acc_d     = acc_q;
    product_d = product_q;
    neg_d     = neg_q;
    if (load) begin
      mcand_d = {{WIDTH{1'b0}}, a_mag};
      mult_d  = b_mag;
      acc_d   = '0;
      neg_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
    end else if (run) begin
      if (mult_q[0]) acc_d = acc_q + mcand_q;
      mcand_d = mcand_q << 1;
      mult_d  = mult_q >> 1;
    end else if (fix) begin
      product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mult_q    <= '0;
      acc_q     <= '0;
      product_q <= '0;
      neg_q     <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mult_q    <= mult_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      neg_q     <= neg_d;
    end
  end

  assign product = product_q;

endmodule
